regfile_neg: RTL and testbench

Parametrised negative-edge-written register file with a per-entry busy scoreboard for the pipelined LC-3 datapath. The upstream posedge pipeline issues and writes back. All state updates on the falling edge of clk, so a writeback is visible to decode reads in the same cycle. Busy bits drive the hazard/stall unit. Replaces the ad-hoc array of single negedge registers.

---
 rtl/regfile_neg.sv | 55 +++++
 tb/tb_regfile_neg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_neg.sv
// regfile_neg: negedge-written register file with a per-entry busy scoreboard
// Ports: clk (state changes on negedge), rst_n (sync active-low, negedge),
//   wr_en/wr_addr/wr_data/wr_clr_busy (write + optional busy clear),
//   busy_set/busy_addr (mark entry busy on issue),
//   rd_addr/rd_data/rd_busy (NREAD packed combinational read ports), busy (scoreboard)
module regfile_neg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int NREAD = 2,
  parameter int WRITE_THROUGH = 0,
  parameter int ZERO_R0 = 0,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_clr_busy,
  input  logic                   busy_set,
  input  logic [AW-1:0]          busy_addr,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  output logic [DEPTH-1:0]       busy
);
  localparam logic [DEPTH-1:0] ZMASK = ZERO_R0 != 0 ? DEPTH'(1) : '0;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic wr_ok, set_ok;
  assign wr_ok = wr_en && 32'(wr_addr) < DEPTH && !(ZERO_R0 != 0 && wr_addr == '0);
  assign set_ok = busy_set && 32'(busy_addr) < DEPTH && !(ZERO_R0 != 0 && busy_addr == '0);
  // set is applied after clear so a same-edge issue overrides the old writeback
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      if (wr_ok && wr_clr_busy) busy_q[wr_addr] <= 1'b0;
      if (set_ok) busy_q[busy_addr] <= 1'b1;
    end
  end
  assign busy = busy_q & ~ZMASK;
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    assign a = rd_addr[g*AW +: AW];
    assign hit = 32'(a) < DEPTH && !(ZERO_R0 != 0 && a == '0);
    assign rd_data[g*WIDTH +: WIDTH] = !hit ? '0
                                     : (WRITE_THROUGH != 0 && wr_en && wr_addr == a) ? wr_data
                                     : mem[a];
    assign rd_busy[g] = hit && busy[a];
  end
endmodule

// File: tb/tb_regfile_neg.sv
// tb_regfile_neg: table, directed and random checks of three regfile_neg configurations
module tb_regfile_neg;
  logic clk, rst_n, wr_en, wr_clr_busy, busy_set;
  logic [2:0] wr_addr, busy_addr, r0, r1;
  logic [31:0] wr_data;
  logic [5:0] rd_addr;
  logic [31:0] rd_a, rd_b;
  logic [63:0] rd_c;
  logic [1:0] rb_a, rb_b, rb_c;
  logic [7:0] bz_a, bz_b;
  logic [5:0] bz_c;
  int nvec = 0, nerr = 0;

  assign rd_addr = {r1, r0};

  regfile_neg u_a (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[15:0]),
    .wr_clr_busy(wr_clr_busy), .busy_set(busy_set), .busy_addr(busy_addr), .rd_addr(rd_addr),
    .rd_data(rd_a), .rd_busy(rb_a), .busy(bz_a));
  regfile_neg #(.WRITE_THROUGH(1)) u_b (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data[15:0]), .wr_clr_busy(wr_clr_busy), .busy_set(busy_set), .busy_addr(busy_addr),
    .rd_addr(rd_addr), .rd_data(rd_b), .rd_busy(rb_b), .busy(bz_b));
  regfile_neg #(.WIDTH(32), .DEPTH(6), .ZERO_R0(1), .WRITE_THROUGH(1)) u_c (.clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr_busy(wr_clr_busy), .busy_set(busy_set),
    .busy_addr(busy_addr), .rd_addr(rd_addr), .rd_data(rd_c), .rd_busy(rb_c), .busy(bz_c));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int dep [3] = '{8, 8, 6};
  bit wt [3] = '{0, 1, 1};
  bit zr [3] = '{0, 0, 1};
  logic [31:0] msk [3] = '{32'hFFFF, 32'hFFFF, 32'hFFFF_FFFF};
  logic [31:0] mm [3][8];
  logic [7:0] mb [3];

  function automatic logic [31:0] exp_rd(int k, logic [2:0] a);
    if (int'(a) >= dep[k] || (zr[k] && a == 0)) return 0;
    if (wt[k] && wr_en && wr_addr == a) return wr_data & msk[k];
    return mm[k][a];
  endfunction

  function automatic logic [31:0] exp_rb(int k, logic [2:0] a);
    return (int'(a) < dep[k]) ? 32'(mb[k][a]) : 0;
  endfunction

  function automatic logic [31:0] act_rd(int k, int p);
    return k == 0 ? {16'h0, rd_a[p*16 +: 16]} : k == 1 ? {16'h0, rd_b[p*16 +: 16]} : rd_c[p*32 +: 32];
  endfunction

  function automatic logic [31:0] act_rb(int k, int p);
    return k == 0 ? 32'(rb_a[p]) : k == 1 ? 32'(rb_b[p]) : 32'(rb_c[p]);
  endfunction

  function automatic logic [31:0] act_bz(int k);
    return k == 0 ? 32'(bz_a) : k == 1 ? 32'(bz_b) : 32'(bz_c);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check(input string tag);
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("%s u%0d rd_data[%0d]", tag, k, p), act_rd(k, p), exp_rd(k, p == 0 ? r0 : r1));
        chk($sformatf("%s u%0d rd_busy[%0d]", tag, k, p), act_rb(k, p), exp_rb(k, p == 0 ? r0 : r1));
      end
      chk($sformatf("%s u%0d busy", tag, k), act_bz(k), 32'(mb[k]));
    end
  endtask

  task automatic drive(input logic r, we, input logic [2:0] wa, input logic [31:0] wd,
                       input logic clr, bs, input logic [2:0] ba, a0, a1);
    @(posedge clk);
    #1;
    rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_clr_busy = clr;
    busy_set = bs; busy_addr = ba; r0 = a0; r1 = a1;
    #1;
    check("pre");
  endtask

  task automatic fall();
    bit wo, so;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mb[k] = 0;
        for (int a = 0; a < 8; a++) mm[k][a] = 0;
      end else begin
        wo = wr_en && int'(wr_addr) < dep[k] && !(zr[k] && wr_addr == 0);
        so = busy_set && int'(busy_addr) < dep[k] && !(zr[k] && busy_addr == 0);
        if (wo) mm[k][wr_addr] = wr_data & msk[k];
        if (wo && wr_clr_busy && !(so && busy_addr == wr_addr)) mb[k][wr_addr] = 1'b0;
        if (so) mb[k][busy_addr] = 1'b1;
      end
    end
    #1;
    check("post");
  endtask

  task automatic step(input logic r, we, input logic [2:0] wa, input logic [31:0] wd,
                      input logic clr, bs, input logic [2:0] ba, a0, a1);
    drive(r, we, wa, wd, clr, bs, ba, a0, a1);
    fall();
  endtask

  typedef struct {
    logic r, we; logic [2:0] wa; logic [31:0] wd; logic clr, bs; logic [2:0] ba, a0, a1;
    logic [15:0] e0, e1; logic [1:0] erb; logic [7:0] eb;
  } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{0, 0, 0, 32'h0,    0, 0, 0, 3, 4, 16'h0,    16'h0,    2'b00, 8'h00};
    tbl[1]  = '{1, 1, 3, 32'h1234, 0, 0, 0, 3, 4, 16'h1234, 16'h0,    2'b00, 8'h00};
    tbl[2]  = '{0, 1, 3, 32'h5555, 1, 1, 3, 3, 4, 16'h0,    16'h0,    2'b00, 8'h00};
    tbl[3]  = '{1, 1, 5, 32'hBEEF, 0, 0, 0, 5, 4, 16'hBEEF, 16'h0,    2'b00, 8'h00};
    tbl[4]  = '{1, 0, 0, 32'h0,    0, 1, 2, 2, 5, 16'h0,    16'hBEEF, 2'b01, 8'h04};
    tbl[5]  = '{1, 1, 2, 32'h0042, 1, 0, 0, 2, 5, 16'h0042, 16'hBEEF, 2'b00, 8'h00};
    tbl[6]  = '{1, 0, 0, 32'h0,    0, 1, 6, 6, 2, 16'h0,    16'h0042, 2'b01, 8'h40};
    tbl[7]  = '{1, 1, 6, 32'h7777, 1, 1, 6, 6, 2, 16'h7777, 16'h0042, 2'b01, 8'h40};
    tbl[8]  = '{1, 1, 6, 32'h8888, 1, 1, 1, 6, 1, 16'h8888, 16'h0,    2'b10, 8'h02};
    tbl[9]  = '{1, 0, 1, 32'h9999, 1, 0, 0, 1, 5, 16'h0,    16'hBEEF, 2'b01, 8'h02};
    tbl[10] = '{1, 0, 0, 32'h0,    0, 1, 3, 3, 6, 16'h0,    16'h8888, 2'b01, 8'h0A};
    for (int k = 0; k < 3; k++) begin
      mb[k] = 0;
      for (int a = 0; a < 8; a++) mm[k][a] = 0;
    end
    rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_clr_busy = 0;
    busy_set = 0; busy_addr = 0; r0 = 0; r1 = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].clr, tbl[i].bs, tbl[i].ba, tbl[i].a0, tbl[i].a1);
      chk($sformatf("tbl%0d rd_data[0]", i), {16'h0, rd_a[15:0]}, {16'h0, tbl[i].e0});
      chk($sformatf("tbl%0d rd_data[1]", i), {16'h0, rd_a[31:16]}, {16'h0, tbl[i].e1});
      chk($sformatf("tbl%0d rd_busy", i), 32'(rb_a), 32'(tbl[i].erb));
      chk($sformatf("tbl%0d busy", i), 32'(bz_a), 32'(tbl[i].eb));
    end
    step(1, 1, 7, 32'h0001, 0, 0, 0, 7, 0);
    drive(1, 1, 7, 32'hFFFF, 0, 0, 0, 7, 0);
    chk("wt pre-edge forwarded", {16'h0, rd_b[15:0]}, 32'hFFFF);
    chk("no-wt pre-edge held", {16'h0, rd_a[15:0]}, 32'h0001);
    chk("wt out-of-range pre-edge", rd_c[31:0], 32'h0);
    fall();
    chk("no-wt post-edge", {16'h0, rd_a[15:0]}, 32'hFFFF);
    drive(1, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    chk("r0 zero under wt", rd_c[31:0], 32'h0);
    chk("r0 forwarded when not zeroed", {16'h0, rd_b[15:0]}, 32'hBEEF);
    fall();
    chk("r0 write dropped", rd_c[31:0], 32'h0);
    step(1, 0, 0, 32'h0, 0, 1, 0, 0, 0);
    chk("r0 busy dropped", 32'(bz_c[0]), 32'h0);
    chk("r0 busy set unzeroed", 32'(bz_a[0]), 32'h1);
    step(1, 1, 7, 32'h12345678, 1, 1, 7, 7, 7);
    chk("oor read data", rd_c[63:32], 32'h0);
    chk("oor rd_busy", 32'(rb_c), 32'h0);
    step(1, 1, 5, 32'hCAFEF00D, 0, 0, 0, 5, 7);
    chk("r5 stored", rd_c[31:0], 32'hCAFEF00D);
    repeat (400) begin
      step($urandom_range(0, 31) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
